// File: rtl/mul_pkg.sv
// mul_pkg -- shared definitions for the shift-free repeated-add multiplier
// scheduler: FSM state encoding and default operand width / requester count.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned W_DEF = 8;
    localparam int unsigned N_DEF = 4;

endpackage

// File: rtl/mul_sched_if.sv
// mul_sched_if -- requester-side bus of the shared multiplier.
//   req     : per-requester request level (bit i = requester i)
//   a_in    : packed multiplicands, slice i*W +: W for requester i
//   b_in    : packed multipliers (iteration counts), same slicing
//   gnt     : one-hot pulse, operands of that requester captured
//   done    : one-hot pulse to the owning requester, product valid
//   product : result of the last completed job, held until the next
//   busy    : scheduler is not idle
// Modports: master = requester side, slave = scheduler side.
interface mul_sched_if
    import mul_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned N = N_DEF
);
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [2*W-1:0] product;
    logic           busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, product, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, product, busy
    );
endinterface

// File: rtl/mul_rr_arb.sv
// mul_rr_arb -- combinational round-robin selector.
//   req    : request vector
//   ptr    : requester with highest priority this round
//   winner : one-hot of the first set req bit searching ptr upward mod N
//   index  : binary index of winner
//   any    : at least one request present
module mul_rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] index,
    output logic          any
);
    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any           = 1'b1;
                winner[cand]  = 1'b1;
                index         = cand;
            end
        end
    end
endmodule

// File: rtl/mul_sched.sv
// mul_sched -- N requesters share one repeated-addition multiplier.
// A job multiplies a by b by adding a into a 2W accumulator b times, so a
// job occupies the unit for b+3 cycles (grant, b adds, done, back to idle).
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : mul_sched_if slave modport (req/a_in/b_in in; gnt/done/product/busy out)
module mul_sched
    import mul_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned N = N_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mul_sched_if.slave      bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [2*W-1:0] total_q, total_d;
    logic [2*W-1:0] product_q, product_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           busy_q, busy_d;

    logic [N-1:0]   win_oh;
    logic [IW-1:0]  win_idx;
    logic           win_any;
    logic [W-1:0]   a_sel, b_sel;

    mul_rr_arb #(.N(N), .IW(IW)) u_arb (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (win_oh),
        .index  (win_idx),
        .any    (win_any)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_oh[i]) begin
                a_sel = bus.a_in[i*W +: W];
                b_sel = bus.b_in[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        x_d       = x_q;
        y_d       = y_q;
        total_d   = total_q;
        product_d = product_q;
        gnt_d     = '0;
        done_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    x_d     = a_sel;
                    y_d     = b_sel;
                    total_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (y_q != '0) begin
                    total_d = total_q + {{W{1'b0}}, x_q};
                    y_d     = y_q - 1'b1;
                end else begin
                    product_d      = total_q;
                    done_d[owner_q] = 1'b1;
                    // Priority moves past the finished owner only on completion.
                    ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            total_q   <= '0;
            product_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            x_q       <= x_d;
            y_q       <= y_d;
            total_q   <= total_d;
            product_q <= product_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched -- directed bench for mul_sched with a job-level reference
// model (grant/done/idle cycles and a*b computed arithmetically per job).
module tb_mul_sched;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mul_sched_if #(.W(W), .N(N)) bus ();

    mul_sched #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned total_cnt = 0;
    int unsigned bad_cnt   = 0;
    int          cyc       = 0;
    bit          chk_en    = 1'b0;

    // Job-level model state
    int             m_gnt_cyc  = -1;
    int             m_done_cyc = -1;
    int             m_free_at  = 0;
    int             m_owner    = 0;
    int             m_ptr      = 0;
    int             m_j        = 0;
    bit             m_found    = 1'b0;
    logic [2*W-1:0] m_prod     = '0;
    logic [2*W-1:0] m_held     = '0;
    logic [2*W-1:0] m_ta, m_tb;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
    endtask

    // Model: on each edge decide what the scheduler must do from the job rules.
    always @(posedge clk) begin
        if (!rst) begin
            chk_en     = 1'b1;
            m_gnt_cyc  = -1;
            m_done_cyc = -1;
            m_free_at  = cyc + 1;
            m_ptr      = 0;
            m_held     = '0;
        end else begin
            if (cyc + 1 == m_done_cyc) begin
                m_held = m_prod;
                m_ptr  = (m_owner + 1) % N;
            end
            if (cyc >= m_free_at && bus.req != '0) begin
                m_found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_j = (m_ptr + i) % N;
                    if (!m_found && bus.req[m_j]) begin
                        m_found = 1'b1;
                        m_owner = m_j;
                    end
                end
                m_ta = '0;
                m_tb = '0;
                m_ta[W-1:0] = bus.a_in[m_owner*W +: W];
                m_tb[W-1:0] = bus.b_in[m_owner*W +: W];
                m_prod     = m_ta * m_tb;
                m_gnt_cyc  = cyc + 1;
                m_done_cyc = cyc + int'(m_tb) + 2;
                m_free_at  = cyc + int'(m_tb) + 3;
            end
        end
        cyc = cyc + 1;
    end

    // Compare every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] oh;
            oh = N'(1) << m_owner;
            check("gnt",     bus.gnt,     (cyc == m_gnt_cyc)  ? oh : '0);
            check("done",    bus.done,    (cyc == m_done_cyc) ? oh : '0);
            check("product", bus.product, m_held);
            check("busy",    bus.busy,    (cyc >= m_gnt_cyc && cyc <= m_done_cyc) ? 1 : 0);
            check("onehot_excl",
                  ($onehot0(bus.gnt) && $onehot0(bus.done) && !((|bus.gnt) && (|bus.done))) ? 1 : 0, 1);
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    // Single requester job; cycle 0 = cycle whose closing edge samples req.
    task automatic run_job(input int i, input int a, input int b, input int exp_prod);
        @(negedge clk);
        set_op(i, W'(a), W'(b));
        bus.req = N'(1) << i;
        @(negedge clk);
        check("job_gnt", bus.gnt, N'(1) << i);
        bus.req = '0;
        repeat (b + 1) @(negedge clk);
        check("job_done", bus.done, N'(1) << i);
        check("job_product", bus.product, exp_prod);
        @(negedge clk);
        check("job_idle", bus.busy, 0);
    endtask

    initial begin
        int order [5];
        int exp_order [5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_product", bus.product, 0);
        rst = 1'b1;

        // Contention: all four held, b=2 each, ptr starts at 0
        @(negedge clk);
        for (int i = 0; i < N; i++) set_op(i, W'(i + 2), 8'd2);
        bus.req = '1;
        n = 0;
        for (int t = 0; t < 40 && n < 5; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                for (int i = 0; i < N; i++) if (bus.gnt[i]) order[n] = i;
                n++;
            end
        end
        bus.req = '0;
        check("cont_grants", n, 5);
        for (int k = 0; k < 5; k++) check("cont_order", order[k], exp_order[k]);
        wait_idle();

        // Single job and edge operands
        run_job(0, 7, 5, 35);
        run_job(1, 0, 3, 0);
        run_job(3, 9, 0, 0);
        run_job(2, 255, 255, 65025);

        // Reset mid-RUN, then ptr must be back at 0 (ptr was 3 before)
        @(negedge clk);
        set_op(0, 8'd3, 8'd10);
        bus.req = 4'b0001;
        @(negedge clk);
        check("rr_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_product", bus.product, 0);
        rst = 1'b1;
        @(negedge clk);
        set_op(0, 8'd5, 8'd1);
        set_op(3, 8'd6, 8'd2);
        bus.req = 4'b1001;
        @(negedge clk);
        check("post_rst_gnt", bus.gnt, 4'b0001);
        bus.req = 4'b1000;
        repeat (4) @(negedge clk);
        check("second_gnt", bus.gnt, 4'b1000);
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("second_done", bus.done, 4'b1000);
        check("second_product", bus.product, 12);
        wait_idle();

        // Operand change during RUN is ignored
        @(negedge clk);
        set_op(0, 8'd4, 8'd3);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        set_op(0, 8'd99, 8'd200);
        repeat (3) @(negedge clk);
        check("opchg_done", bus.done, 4'b0001);
        check("opchg_product", bus.product, 12);
        wait_idle();

        // Back-to-back: req1 held through completion
        @(negedge clk);
        set_op(1, 8'd2, 8'd2);
        bus.req = 4'b0010;
        @(negedge clk);
        check("b2b_gnt1", bus.gnt, 4'b0010);
        repeat (3) @(negedge clk);
        check("b2b_done1", bus.done, 4'b0010);
        check("b2b_prod1", bus.product, 4);
        set_op(1, 8'd5, 8'd2);
        repeat (2) @(negedge clk);
        check("b2b_gnt2", bus.gnt, 4'b0010);
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("b2b_done2", bus.done, 4'b0010);
        check("b2b_prod2", bus.product, 10);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total_cnt, bad_cnt);
        $fatal(1, "watchdog");
    end
endmodule
